up_counter_with_pause_function: RTL and testbench
=================================================

UP_COUNTER_WITH_PAUSE_FUNCTION -- requirements
Module: up_counter_with_pause_function

Interface
REQ-001 SHALL have parameter LIMIT1, default 3, meaning tens BCD digit of the terminal count (legal 0..9).
REQ-002 SHALL have parameter LIMIT0, default 0, meaning ones BCD digit of the terminal count (legal 0..9); LIMIT1:LIMIT0 SHALL NOT be 00.
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_before  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port tick_1hz  input  1  count enable, one clk cycle high per second.
REQ-006 SHALL have port press  input  1  debounced start/pause button level, active-high.
REQ-007 SHALL have port scan  input  1  display digit select level (0 = ones, 1 = tens).
REQ-008 SHALL have port digit0  output  4  ones BCD digit of the count.
REQ-009 SHALL have port digit1  output  4  tens BCD digit of the count.
REQ-010 SHALL have port show  output  8  seven-segment pattern of the selected digit, active-low.
REQ-011 SHALL have port ssd_active  output  4  digit anode enables, active-low.
REQ-012 SHALL have port state_led  output  1  1 while counting.
REQ-013 SHALL have port done  output  1  1 while the count is held at the terminal value.
REQ-014 SHALL have port led  output  15  all ones while done, else all zeros.

Function
REQ-015 SHALL register press each cycle and form press_edge = press AND NOT previous press; only press_edge SHALL affect the FSM.
REQ-016 SHALL implement FSM states PAUSE, COUNT, DONE.
REQ-017 PAUSE: press_edge -> COUNT; tick_1hz ignored; count held.
REQ-018 COUNT: press_edge -> PAUSE with no increment that cycle, even if tick_1hz is also high.
REQ-019 COUNT: tick_1hz without press_edge -> increment count by one in BCD; digit0 9 wraps to 0 and increments digit1 in the same cycle.
REQ-020 COUNT: the increment that makes digit1:digit0 equal LIMIT1:LIMIT0 SHALL move the FSM to DONE on the same clock edge.
REQ-021 DONE: tick_1hz ignored, count held at limit; press_edge clears count to 00 and moves to PAUSE.
REQ-022 State change and count update SHALL occur at the first clk edge where press_edge or tick_1hz is sampled (one-cycle latency to outputs).
REQ-023 state_led SHALL be 1 exactly in COUNT; done and led SHALL be driven exactly in DONE.
REQ-024 Display SHALL be combinational: scan=0 -> show = pattern(digit0), ssd_active = 4'b1110; scan=1 -> show = pattern(digit1), ssd_active = 4'b1101.
REQ-025 digit0 and digit1 SHALL never leave 0..9.

Reset
REQ-026 rst_before low SHALL immediately, regardless of clk, force PAUSE, digit1:digit0 = 00, press history = 0, state_led = 0, done = 0, led = 0.
REQ-027 Reset asserted mid-count SHALL discard the count; after release the block waits for a fresh press_edge (a press held through release SHALL NOT start counting).

Structure
REQ-028 A shared package SHALL hold the FSM state encodings, the BCD-to-segment pattern table (active-low, dp off) and the two ssd_active constants.
REQ-029 One sub-module, bcd_up_digit (single BCD digit with enable, clear, wrap at 9 and carry out), SHALL be instantiated twice, ones carry driving tens enable.

Verification
REQ-030 Reset during COUNT at 17 -> digit 00, state_led 0, led 0 asynchronously; press held through release -> stays PAUSE.
REQ-031 Press edge, 12 ticks -> 12, state_led 1; press edge -> PAUSE; 3 more ticks -> still 12.
REQ-032 Count at 09, one tick -> digit1=1, digit0=0 on the next edge.
REQ-033 Defaults, 30 ticks from 00 -> 30, done=1, led=15'h7FFF, state_led 0; 5 extra ticks -> still 30; press edge -> 00, PAUSE, led 0.
REQ-034 COUNT at 05, press edge and tick_1hz in same cycle -> stays 05, PAUSE.
REQ-035 Count 27: scan=0 -> show=pattern(7), ssd_active=4'b1110; scan=1 -> show=pattern(2), ssd_active=4'b1101.

Source files
------------

// File: rtl/up_counter_with_pause_function_pkg.sv
// Shared types and constants for the pausable two-digit BCD up counter.
// Holds FSM state encodings, the seven-segment table and anode constants.
package up_counter_with_pause_function_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SSD_ONES = 4'b1110;
    localparam logic [3:0] SSD_TENS = 4'b1101;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp kept off.
    function automatic logic [7:0] seg_pattern(input logic [3:0] d);
        logic [7:0] p;
        unique case (d)
            4'd0:    p = 8'hC0;
            4'd1:    p = 8'hF9;
            4'd2:    p = 8'hA4;
            4'd3:    p = 8'hB0;
            4'd4:    p = 8'h99;
            4'd5:    p = 8'h92;
            4'd6:    p = 8'h82;
            4'd7:    p = 8'hF8;
            4'd8:    p = 8'h80;
            4'd9:    p = 8'h90;
            default: p = 8'hFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/up_counter_with_pause_function_bcd_up_digit.sv
// Single BCD digit: clear has priority, enable increments and wraps 9->0.
// Ports: clk, rst_n, en, clr in; q (digit) and carry (wrap this cycle) out.
module bcd_up_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = en & (q == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/up_counter_with_pause_function.sv
// Two-digit BCD up counter with start/pause button and terminal hold.
// Ports: clk, rst_before, tick_1hz, press, scan in; digits, display, status out.
module up_counter_with_pause_function
    import up_counter_with_pause_function_pkg::*;
#(
    parameter int LIMIT1 = 3,
    parameter int LIMIT0 = 0
) (
    input  logic        clk,
    input  logic        rst_before,
    input  logic        tick_1hz,
    input  logic        press,
    input  logic        scan,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [7:0]  show,
    output logic [3:0]  ssd_active,
    output logic        state_led,
    output logic        done,
    output logic [14:0] led
);

    localparam logic [3:0] LIM1 = 4'(LIMIT1);
    localparam logic [3:0] LIM0 = 4'(LIMIT0);

    state_t     state;
    logic       press_q;
    logic       primed;
    logic       press_edge;
    logic       inc;
    logic       clr;
    logic       c0;
    logic       c1;
    logic [3:0] nxt0;
    logic [3:0] nxt1;
    logic       at_limit;

    // primed blanks the first sample after reset so a button held
    // through release is not mistaken for a fresh press.
    always_ff @(posedge clk or negedge rst_before) begin
        if (!rst_before) begin
            press_q <= 1'b0;
            primed  <= 1'b0;
        end else begin
            press_q <= press;
            primed  <= 1'b1;
        end
    end

    assign press_edge = primed & press & ~press_q;

    assign inc = (state == ST_COUNT) & tick_1hz & ~press_edge;
    assign clr = (state == ST_DONE) & press_edge;

    bcd_up_digit u_ones (
        .clk   (clk),
        .rst_n (rst_before),
        .en    (inc),
        .clr   (clr),
        .q     (digit0),
        .carry (c0)
    );

    bcd_up_digit u_tens (
        .clk   (clk),
        .rst_n (rst_before),
        .en    (c0),
        .clr   (clr),
        .q     (digit1),
        .carry (c1)
    );

    // Value the digits take on this edge when inc is high.
    assign nxt0 = c0 ? 4'd0 : digit0 + 4'd1;
    assign nxt1 = c0 ? (c1 ? 4'd0 : digit1 + 4'd1) : digit1;
    assign at_limit = inc & (nxt1 == LIM1) & (nxt0 == LIM0);

    always_ff @(posedge clk or negedge rst_before) begin
        if (!rst_before) begin
            state     <= ST_PAUSE;
            state_led <= 1'b0;
            done      <= 1'b0;
            led       <= '0;
        end else begin
            unique case (state)
                ST_PAUSE: begin
                    if (press_edge) begin
                        state     <= ST_COUNT;
                        state_led <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (press_edge) begin
                        state     <= ST_PAUSE;
                        state_led <= 1'b0;
                    end else if (at_limit) begin
                        state     <= ST_DONE;
                        state_led <= 1'b0;
                        done      <= 1'b1;
                        led       <= '1;
                    end
                end
                ST_DONE: begin
                    if (press_edge) begin
                        state <= ST_PAUSE;
                        done  <= 1'b0;
                        led   <= '0;
                    end
                end
                default: begin
                    state     <= ST_PAUSE;
                    state_led <= 1'b0;
                    done      <= 1'b0;
                    led       <= '0;
                end
            endcase
        end
    end

    always_comb begin
        show       = seg_pattern(scan ? digit1 : digit0);
        ssd_active = scan ? SSD_TENS : SSD_ONES;
    end

endmodule

// File: tb/tb_up_counter_with_pause_function.sv
// Scoreboard bench for the pausable BCD counter with a behavioural model.
// Stimulus pushes expected outputs per edge; a monitor pops and compares.
module tb_up_counter_with_pause_function;

    logic        clk = 1'b0;
    logic        rst_before = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        press = 1'b0;
    logic        scan = 1'b0;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [7:0]  show;
    logic [3:0]  ssd_active;
    logic        state_led;
    logic        done;
    logic [14:0] led;

    localparam int LIMIT = 30;

    up_counter_with_pause_function #(.LIMIT1(3), .LIMIT0(0)) dut (
        .clk        (clk),
        .rst_before (rst_before),
        .tick_1hz   (tick_1hz),
        .press      (press),
        .scan       (scan),
        .digit0     (digit0),
        .digit1     (digit1),
        .show       (show),
        .ssd_active (ssd_active),
        .state_led  (state_led),
        .done       (done),
        .led        (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          d0;
        int          d1;
        bit          sl;
        bit          dn;
        logic [14:0] led;
        logic [7:0]  show;
        logic [3:0]  ssd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // model: 0 paused, 1 counting, 2 held at limit
    int m_mode;
    int m_count;
    bit m_prev;
    bit m_primed;

    function automatic logic [7:0] pat(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_count = 0;
        m_prev = 0;
        m_primed = 0;
    endtask

    task automatic model_step(input bit p, input bit t);
        bit e;
        e = m_primed && p && !m_prev;
        case (m_mode)
            0: if (e) m_mode = 1;
            1: begin
                if (e) m_mode = 0;
                else if (t) begin
                    m_count++;
                    if (m_count == LIMIT) m_mode = 2;
                end
            end
            default: if (e) begin
                m_count = 0;
                m_mode = 0;
            end
        endcase
        m_prev = p;
        m_primed = 1;
    endtask

    task automatic cycle(input bit p, input bit t, input bit s);
        exp_t e;
        int   sel;
        @(negedge clk);
        rst_before = 1'b1;
        press = p;
        tick_1hz = t;
        scan = s;
        model_step(p, t);
        e.d0 = m_count % 10;
        e.d1 = m_count / 10;
        e.sl = (m_mode == 1);
        e.dn = (m_mode == 2);
        e.led = (m_mode == 2) ? 15'h7FFF : 15'h0000;
        sel = s ? e.d1 : e.d0;
        e.show = pat(sel);
        e.ssd = s ? 4'b1101 : 4'b1110;
        sb.push_back(e);
    endtask

    task automatic pulse();
        cycle(1, 0, 1'($urandom));
        cycle(0, 0, 1'($urandom));
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cycle(0, 1, 1'($urandom));
            if ($urandom % 2 == 1) cycle(0, 0, 1'($urandom));
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_count(input string name, input int d1,
                             input int d0, input bit sl);
        chk({name, "_d1"}, 32'(digit1), 32'(d1));
        chk({name, "_d0"}, 32'(digit0), 32'(d0));
        chk({name, "_sl"}, 32'(state_led), 32'(sl));
    endtask

    task automatic do_reset(input bit hold);
        wait (sb.size() == 0);
        #2;
        rst_before = 1'b0;
        press = hold;
        tick_1hz = 1'b0;
        #1;
        chk("rst_d0", 32'(digit0), 0);
        chk("rst_d1", 32'(digit1), 0);
        chk("rst_sl", 32'(state_led), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_led", 32'(led), 0);
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_d0", 32'(digit0), 32'(e.d0));
                chk("sb_d1", 32'(digit1), 32'(e.d1));
                chk("sb_sl", 32'(state_led), 32'(e.sl));
                chk("sb_done", 32'(done), 32'(e.dn));
                chk("sb_led", 32'(led), 32'(e.led));
                chk("sb_show", 32'(show), 32'(e.show));
                chk("sb_ssd", 32'(ssd_active), 32'(e.ssd));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        #3;
        chk("init_d0", 32'(digit0), 0);
        chk("init_d1", 32'(digit1), 0);
        chk("init_sl", 32'(state_led), 0);
        chk("init_led", 32'(led), 0);
        cycle(0, 0, 0);

        pulse();
        ticks(12);
        wait_edge();
        chk_count("c12", 1, 2, 1);
        pulse();
        ticks(3);
        wait_edge();
        chk_count("pause12", 1, 2, 0);

        pulse();
        ticks(5);
        wait_edge();
        chk_count("c17", 1, 7, 1);
        do_reset(1);
        repeat (3) cycle(1, 0, 0);
        repeat (4) cycle(1, 1, 0);
        wait_edge();
        chk_count("held", 0, 0, 0);

        cycle(0, 0, 0);
        pulse();
        ticks(9);
        wait_edge();
        chk_count("c09", 0, 9, 1);
        cycle(0, 1, 0);
        wait_edge();
        chk_count("c10", 1, 0, 1);

        do_reset(0);
        cycle(0, 0, 0);
        pulse();
        ticks(5);
        cycle(1, 1, 0);
        wait_edge();
        chk_count("both05", 0, 5, 0);

        cycle(0, 0, 0);
        pulse();
        ticks(22);
        cycle(0, 0, 0);
        wait_edge();
        chk("s0_show", 32'(show), 32'(8'hF8));
        chk("s0_ssd", 32'(ssd_active), 32'(4'b1110));
        cycle(0, 0, 1);
        wait_edge();
        chk("s1_show", 32'(show), 32'(8'hA4));
        chk("s1_ssd", 32'(ssd_active), 32'(4'b1101));

        ticks(3);
        wait_edge();
        chk_count("lim30", 3, 0, 0);
        chk("lim_done", 32'(done), 1);
        chk("lim_led", 32'(led), 32'(15'h7FFF));
        ticks(5);
        wait_edge();
        chk_count("hold30", 3, 0, 0);
        cycle(1, 0, 0);
        wait_edge();
        chk_count("clr", 0, 0, 0);
        chk("clr_done", 32'(done), 0);
        chk("clr_led", 32'(led), 0);
        cycle(0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 40) == 0, ($urandom % 3) == 0,
                  1'($urandom));
        end
        for (int i = 0; i < 20; i++) begin
            if ($urandom % 50 == 0) do_reset(1'($urandom));
            cycle(($urandom % 40) == 0, 1'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
